led_share_arbiter: RTL and testbench
====================================

LED_SHARE_ARBITER -- requirements
Module: led_share_arbiter

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable samples required to accept a key level change.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: cycles one requester owns the LED bank per grant.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key, input, 4 bits: raw asynchronous push-buttons, active-high; key[i] is requester i.
REQ-006 SHALL have port sw, input, 4 bits: pattern data shown by the granted requester.
REQ-007 SHALL have port led, output, 8 bits: shared LED bank.
REQ-008 SHALL have port grant, output, 4 bits: one-hot current owner; all zero when none.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass each key bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL change debounced level i only after synchronized key[i] differs from it for DEB_CYCLES consecutive cycles; any shorter differing run SHALL reset the count.
REQ-012 SHALL set pending[i] on the cycle the debounced level i rises; falling edges and held levels SHALL generate no request.
REQ-013 SHALL run FSM states IDLE, GRANT and GAP.
REQ-014 In IDLE with any pending bit set, SHALL enter GRANT next cycle; otherwise SHALL stay in IDLE.
REQ-015 On GRANT entry SHALL select the owner by round-robin: search order last_owner+1, +2, +3, +4 (mod 4); first pending bit wins.
REQ-016 On GRANT entry SHALL clear the owner's pending bit, update last_owner, and capture sw into a held register.
REQ-017 If a new rising edge for the owner arrives on the GRANT-entry cycle, SHALL leave pending set (set beats clear).
REQ-018 SHALL remain in GRANT for exactly HOLD_CYCLES cycles, then SHALL enter GAP for exactly 1 cycle, then SHALL enter IDLE.
REQ-019 In GRANT, SHALL drive led[7:4] = one-hot owner, led[3:0] = captured sw, and grant = one-hot owner.
REQ-020 In IDLE and GAP, SHALL drive led = 8'h00 and grant = 4'b0000.
REQ-021 SHALL ignore sw changes during GRANT and key releases during GRANT.
REQ-022 SHALL queue a press by the current owner during its own GRANT as a new pending request, served under round-robin order.
REQ-023 SHALL register all outputs; no combinational path from key or sw to outputs.
REQ-024 From first cycle synchronized-stage-2 key[i] is high, pending[i] SHALL set after DEB_CYCLES cycles; GRANT follows per REQ-014.

Reset
REQ-025 While rst is high at a clock edge: FSM = IDLE, pending = 0, debounced levels = 0, debounce counters = 0, synchronizers = 0, hold counter = 0, last_owner = 3, led = 8'h00, grant = 4'b0000, busy = 0.
REQ-026 Reset asserted mid-GRANT SHALL force all outputs to reset values on the following edge and discard all pending requests.

Structure
REQ-027 Shared package led_arb_pkg SHALL hold the FSM state type, key count (4), LED width (8) and owner-index width (2).
REQ-028 SHALL instantiate a sub-module key_debounce (synchronizer + counter + rise pulse) four times, parameterized by DEB_CYCLES.

Verification (DEB_CYCLES=4, HOLD_CYCLES=8)
REQ-029 Reset, then key=0 for 20 cycles -> led=00, grant=0000, busy=0 throughout.
REQ-030 sw=4'b0101; hold key[2] high -> grant=0100 and led=8'b0100_0101 for exactly 8 cycles, then 1 GAP cycle with led=00, then IDLE.
REQ-031 Pulse key[1] high for 2 cycles (shorter than DEB_CYCLES) -> no pending, no grant, busy stays 0.
REQ-032 Press key[0] and key[2] on the same cycle after reset -> key[0] served first, then key[2] after GAP+IDLE; each held 8 cycles.
REQ-033 Keys 0-3 all pending, owner 0 re-pressed during its GRANT -> service order 0,1,2,3,0.
REQ-034 Assert rst on cycle 3 of a GRANT with sw=4'b1111 -> next edge led=00, grant=0000, busy=0; no grant follows without a new press.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and sizes for the LED-sharing arbiter and its key debouncers.
package led_arb_pkg;

    localparam int NUM_KEYS = 4;
    localparam int LED_W    = 8;
    localparam int OWNER_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Round-robin pick: the first pending requester after 'last', wrapping around.
    // Scanning from the far end down lets the nearest hit overwrite the others.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [NUM_KEYS-1:0] pend,
                                                  input logic [OWNER_W-1:0]  last);
        logic [OWNER_W-1:0] idx;
        rr_pick = last;
        for (int k = NUM_KEYS; k >= 1; k--) begin
            idx = last + OWNER_W'(k);
            if (pend[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [NUM_KEYS-1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
        owner_onehot      = '0;
        owner_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and a rise pulse
// that is high on the cycle the debounced level is about to go high.
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             s1_q, s2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differs;
    logic             expire;

    assign differs = (s2_q != level_q);
    assign expire  = differs && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    // The pulse coincides with the edge that flips level_q, so a register fed
    // by it sets on the same edge the debounced level rises.
    assign rise_o  = expire & s2_q;

    // Bring the raw key into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (differs) begin
            if (expire) begin
                level_q <= s2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/led_share_arbiter.sv
// Four debounced push-buttons share one LED bank. Each press queues a request;
// requests are served round-robin, each owner holding the bank for HOLD_CYCLES
// cycles followed by one blank gap cycle. All outputs are registered.
module led_share_arbiter
    import led_arb_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    input  logic [3:0]          sw,
    output logic [LED_W-1:0]    led,
    output logic [NUM_KEYS-1:0] grant,
    output logic                busy
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] clr;
    logic [OWNER_W-1:0]  pick;
    logic                start;

    arb_state_e          state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [OWNER_W-1:0]  last_owner_q;
    logic [LED_W-1:0]    led_q;
    logic [NUM_KEYS-1:0] grant_q;
    logic                busy_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .key_i (key[g]),
            .rise_o(rise[g])
        );
    end

    // Owner selection and the pending bit it consumes on GRANT entry.
    always_comb begin
        pick  = rr_pick(pending_q, last_owner_q);
        start = (state_q == ST_IDLE) && (|pending_q);
        clr   = '0;
        if (start) clr = owner_onehot(pick);
    end

    // Pending requests: a fresh rise wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= (pending_q & ~clr) | rise;
    end

    // IDLE -> GRANT (HOLD_CYCLES) -> GAP (1) -> IDLE, with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            last_owner_q <= OWNER_W'(NUM_KEYS - 1);
            led_q        <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_GRANT;
                        hold_q       <= '0;
                        last_owner_q <= pick;
                        grant_q      <= owner_onehot(pick);
                        led_q        <= {owner_onehot(pick), sw};
                        busy_q       <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_q <= ST_GAP;
                        hold_q  <= '0;
                        led_q   <= '0;
                        grant_q <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter with DEB_CYCLES=4, HOLD_CYCLES=8.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_led_share_arbiter;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'h0;
    logic [3:0] sw  = 4'h0;
    logic [7:0] led;
    logic [3:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    led_share_arbiter #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .sw   (sw),
        .led  (led),
        .grant(grant),
        .busy (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic int oh_idx(input logic [3:0] g);
        oh_idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) oh_idx = i;
    endfunction

    // ---------------- behavioural model ----------------
    // Sync stages as shift values, debounce as run lengths, ownership as a
    // countdown of remaining lit cycles plus a gap flag.
    logic [3:0] m_s1, m_s2, m_lvl, m_pend, m_sw;
    int         m_run [4];
    int         m_left, m_owner, m_last;
    bit         m_gap;
    logic [3:0] m_rise, m_clr;
    bit         m_found;
    logic [1:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = 0; m_sw = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_left = 0; m_gap = 0; m_last = 3; m_owner = 3;
        end else begin
            m_rise = 0;
            m_clr  = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) m_rise[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_gap = 1;
            end else if (m_gap) begin
                m_gap = 0;
            end else if (m_pend != 0) begin
                m_found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!m_found && m_pend[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        m_found = 1;
                    end
                end
                m_last = m_owner;
                m_left = HOLD;
                m_sw   = sw;
                m_clr[m_owner] = 1'b1;
                exp_q.push_back(2'(m_owner));
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
        end
    end

    function automatic logic [3:0] m_grant_exp();
        m_grant_exp = (m_left > 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("led",   led,   (m_left > 0) ? {m_grant_exp(), m_sw} : 8'h00);
            chk("grant", grant, m_grant_exp());
            chk("busy",  busy,  (m_left > 0) || m_gap);
        end
    end

    // ---------------- grant monitor / scoreboard ----------------
    logic [3:0] prev_grant = 4'h0;
    int         log_q[$];
    int         mon_o, mon_e;

    always @(negedge clk) begin
        if (cmp_en && grant != 4'h0 && prev_grant == 4'h0) begin
            mon_o = oh_idx(grant);
            log_q.push_back(mon_o);
            mon_e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 99;
            chk("sb_owner", mon_o, mon_e);
        end
        prev_grant = grant;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key = 4'h0;
        idle(2);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_grant(input string name, input logic [3:0] want, input int budget);
        int n;
        n = 0;
        while (grant !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, grant, want);
    endtask

    task automatic wait_log(input string name, input int cnt, input int budget);
        int n;
        n = 0;
        while (log_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, log_q.size(), cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, cnt;
        bit seen;

        // Reset and quiet keys: everything dark.
        do_reset();
        cmp_en = 1'b1;
        chk("reset_led", led, 8'h00);
        chk("reset_grant", grant, 4'h0);
        chk("reset_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= busy | (|grant) | (|led);
        end
        chk("quiet_activity", seen, 1'b0);

        // Single hold of key[2] with sw=0101.
        sw  = 4'b0101;
        key = 4'b0100;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (grant == 4'h0 && lat < 50);
        chk("press_latency", lat, 7);
        chk("model_grant_k2", m_grant_exp(), 4'b0100);
        cnt = 0;
        sw  = 4'b1010;
        while (grant == 4'b0100 && led == 8'b0100_0101 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("hold_len", cnt, HOLD);
        chk("gap_led", led, 8'h00);
        chk("gap_busy", busy, 1'b1);
        @(negedge clk);
        chk("after_gap_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("held_no_repeat", seen, 1'b0);
        key = 4'h0;
        idle(12);

        // Short glitch on key[1] is rejected.
        key = 4'b0010;
        idle(2);
        key = 4'h0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("glitch_busy", seen, 1'b0);

        // Simultaneous key[0]+key[2] after reset: 0 then 2.
        do_reset();
        sw  = 4'b0011;
        key = 4'b0101;
        idle(6);
        key = 4'h0;
        wait_log("pair_count", 2, 100);
        chk("pair_first", (log_q.size() > 0) ? log_q[0] : -1, 0);
        chk("pair_second", (log_q.size() > 1) ? log_q[1] : -1, 2);
        idle(12);

        // All four pending, owner 0 re-presses during its grant: 0,1,2,3,0.
        do_reset();
        key = 4'hF;
        idle(4);
        key = 4'h0;
        wait_grant("rr_first_grant", 4'b0001, 40);
        idle(2);
        key = 4'b0001;
        idle(6);
        key = 4'h0;
        wait_log("rr_count", 5, 200);
        for (int i = 0; i < 5; i++) begin
            int want [5] = '{0, 1, 2, 3, 0};
            chk($sformatf("rr_order_%0d", i), (log_q.size() > i) ? log_q[i] : -1, want[i]);
        end
        idle(12);

        // Reset in the third grant cycle.
        do_reset();
        sw  = 4'b1111;
        key = 4'b1000;
        idle(6);
        key = 4'h0;
        wait_grant("rst_case_grant", 4'b1000, 40);
        chk("rst_case_led", led, 8'b1000_1111);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_led", led, 8'h00);
        chk("mid_rst_grant", grant, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("post_rst_quiet", seen, 1'b0);

        // Randomized key/sw activity against the model.
        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            key = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            sw  = 4'($urandom_range(0, 15));
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
                @(negedge clk);
            end
        end
        key = 4'h0;
        idle(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
